// File: rtl/pattern_buffer_if.sv
// Bus bundle between the pattern buffer store and its users.
// It carries the core field port, the ingress byte stream and the egress byte stream.
interface pattern_buffer_if #(
  parameter int bufp_width   = 3,
  parameter int fieldp_width = 5,
  parameter int buffer_width = 8
);
  logic [bufp_width-1:0]      bufp;
  logic [fieldp_width-1:0]    fieldp;
  logic [buffer_width-1:0]    field_in;
  logic [fieldp_width-1:0]    fieldwp;
  logic [buffer_width-1:0]    field_out;
  logic                       field_wen;
  logic                       buf_done;
  logic [2**bufp_width-1:0]   buf_full;
  logic                       in_valid;
  logic                       in_ready;
  logic [buffer_width-1:0]    in_data;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [buffer_width-1:0]    out_data;
  logic                       out_last;

  modport master (
    output bufp, fieldp, fieldwp, field_out, field_wen, buf_done,
    output in_valid, in_data, in_last, out_ready,
    input  field_in, buf_full, in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  bufp, fieldp, fieldwp, field_out, field_wen, buf_done,
    input  in_valid, in_data, in_last, out_ready,
    output field_in, buf_full, in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pattern_buffer.sv
// Ring of field buffers: the ingress stream fills them, the core edits them, and the egress stream drains them.
// Each buffer cycles FREE -> FILLING -> FULL -> DONE -> DRAINING -> FREE in strict ring order.
module pattern_buffer #(
  parameter int bufp_width   = 3,
  parameter int fieldp_width = 5,
  parameter int buffer_width = 8
) (
  input logic             clk,
  input logic             reset,
  pattern_buffer_if.slave bus
);
  localparam int NBUF = 2**bufp_width;
  localparam int NFLD = 2**fieldp_width;

  typedef enum logic [2:0] {
    B_FREE = 3'd0, B_FILLING = 3'd1, B_FULL = 3'd2, B_DONE = 3'd3, B_DRAINING = 3'd4
  } buf_state_e;

  typedef enum logic [1:0] {E_IDLE = 2'd0, E_LOAD = 2'd1, E_SEND = 2'd2} eg_state_e;

  logic [buffer_width-1:0] mem_q [NBUF*NFLD];
  buf_state_e              state_q [NBUF];
  buf_state_e              state_d [NBUF];
  logic [fieldp_width-1:0] len_q [NBUF];
  logic [fieldp_width-1:0] len_d [NBUF];
  logic [bufp_width-1:0]   fill_ptr_q, fill_ptr_d, drain_ptr_q, drain_ptr_d;
  logic [fieldp_width-1:0] fill_idx_q, fill_idx_d, drain_idx_q, drain_idx_d;
  logic [fieldp_width-1:0] drain_next_s;
  eg_state_e               eg_q, eg_d;
  logic [buffer_width-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [NBUF-1:0]         buf_full_q;
  logic                    run_q;
  logic                    in_ready_s, in_fire_s, fill_close_s;
  logic                    core_wr_s, core_done_s, eg_take_s, eg_free_s;

  // run_q keeps ingress closed until the first clock after reset release
  assign in_ready_s   = run_q && (state_q[fill_ptr_q] == B_FREE || state_q[fill_ptr_q] == B_FILLING);
  assign in_fire_s    = bus.in_valid && in_ready_s;
  assign fill_close_s = bus.in_last || (fill_idx_q == fieldp_width'(NFLD - 1));
  assign core_wr_s    = bus.field_wen && (state_q[bus.bufp] == B_FULL);
  assign core_done_s  = bus.buf_done && (state_q[bus.bufp] == B_FULL);
  assign drain_next_s = drain_idx_q + fieldp_width'(1);

  assign bus.field_in  = mem_q[{bus.bufp, bus.fieldp}];
  assign bus.in_ready  = in_ready_s;
  assign bus.buf_full  = buf_full_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  // Field storage; ingress and core always target different buffers, so both ports may fire together
  always_ff @(posedge clk) begin
    if (in_fire_s) mem_q[{fill_ptr_q, fill_idx_q}] <= bus.in_data;
    if (core_wr_s) mem_q[{bus.bufp, bus.fieldwp}] <= bus.field_out;
  end

  // Per-buffer ownership and length; the three agents own distinct buffers, so their updates never collide
  always_comb begin
    for (int i = 0; i < NBUF; i++) begin
      state_d[i] = state_q[i];
      len_d[i]   = len_q[i];
      if (core_done_s && bus.bufp == bufp_width'(i)) begin
        state_d[i] = B_DONE;
      end else if (in_fire_s && fill_ptr_q == bufp_width'(i)) begin
        state_d[i] = fill_close_s ? B_FULL : B_FILLING;
        len_d[i]   = fill_close_s ? fill_idx_q : len_q[i];
      end else if (eg_take_s && drain_ptr_q == bufp_width'(i)) begin
        state_d[i] = B_DRAINING;
      end else if (eg_free_s && drain_ptr_q == bufp_width'(i)) begin
        state_d[i] = B_FREE;
      end else begin
        state_d[i] = state_q[i];
      end
    end
  end

  // Ingress fill pointer and index
  always_comb begin
    fill_ptr_d = fill_ptr_q;
    fill_idx_d = fill_idx_q;
    if (in_fire_s && fill_close_s) begin
      fill_ptr_d = fill_ptr_q + bufp_width'(1);
      fill_idx_d = '0;
    end else if (in_fire_s) begin
      fill_idx_d = fill_idx_q + fieldp_width'(1);
    end else begin
      fill_idx_d = fill_idx_q;
    end
  end

  // Egress FSM; an accepted non-last byte is replaced by the next one on the same edge
  always_comb begin
    eg_d        = eg_q;
    drain_ptr_d = drain_ptr_q;
    drain_idx_d = drain_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    eg_take_s   = 1'b0;
    eg_free_s   = 1'b0;
    case (eg_q)
      E_IDLE: begin
        if (state_q[drain_ptr_q] == B_DONE) begin
          eg_take_s   = 1'b1;
          drain_idx_d = '0;
          eg_d        = E_LOAD;
        end else begin
          eg_d = E_IDLE;
        end
      end
      E_LOAD: begin
        out_data_d  = mem_q[{drain_ptr_q, drain_idx_q}];
        out_last_d  = (drain_idx_q == len_q[drain_ptr_q]);
        out_valid_d = 1'b1;
        eg_d        = E_SEND;
      end
      E_SEND: begin
        if (out_valid_q && bus.out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          eg_free_s   = 1'b1;
          drain_ptr_d = drain_ptr_q + bufp_width'(1);
          eg_d        = E_IDLE;
        end else if (out_valid_q && bus.out_ready) begin
          drain_idx_d = drain_next_s;
          out_data_d  = mem_q[{drain_ptr_q, drain_next_s}];
          out_last_d  = (drain_next_s == len_q[drain_ptr_q]);
        end else begin
          eg_d = E_SEND;
        end
      end
      default: begin
        eg_d        = E_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Control registers; an asynchronous reset abandons any fill or drain in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NBUF; i++) begin
        state_q[i] <= B_FREE;
        len_q[i]   <= '0;
      end
      buf_full_q  <= '0;
      fill_ptr_q  <= '0;
      fill_idx_q  <= '0;
      drain_ptr_q <= '0;
      drain_idx_q <= '0;
      eg_q        <= E_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NBUF; i++) begin
        state_q[i]    <= state_d[i];
        len_q[i]      <= len_d[i];
        buf_full_q[i] <= (state_d[i] == B_FULL);
      end
      fill_ptr_q  <= fill_ptr_d;
      fill_idx_q  <= fill_idx_d;
      drain_ptr_q <= drain_ptr_d;
      drain_idx_q <= drain_idx_d;
      eg_q        <= eg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      run_q       <= 1'b1;
    end
  end
endmodule

// File: doc/pattern_buffer.md
Name: pattern_buffer

Overview:
Field-buffer store on the far side of the pat core's buffer interface. It serves the core's field reads (bufp/fieldp → field_in) and field writes (fieldwp/field_out). It fills buffers from an ingress byte stream and drains processed buffers to an egress byte stream. Buffers move through a ring-ordered ownership cycle: FREE → FILLING → FULL → DONE → DRAINING → FREE.

Parameters:
bufp_width, 3, buffer-select width; NBUF = 2**bufp_width buffers
fieldp_width, 5, field-index width; NFLD = 2**fieldp_width fields per buffer
buffer_width, 8, field data width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
bufp  input  bufp_width  core buffer select
fieldp  input  fieldp_width  core read field index
field_in  output  buffer_width  field data to core (combinational)
fieldwp  input  fieldp_width  core write field index
field_out  input  buffer_width  core write data
field_wen  input  1  core write strobe
buf_done  input  1  core releases buffer bufp (one-cycle pulse)
buf_full  output  NBUF  per-buffer flag, 1 = FULL (owned by core)
in_valid  input  1  ingress byte valid
in_ready  output  1  ingress can accept
in_data  input  buffer_width  ingress byte
in_last  input  1  last byte of pattern
out_valid  output  1  egress byte valid
out_ready  input  1  egress sink accepts
out_data  output  buffer_width  egress byte
out_last  output  1  last byte of buffer

Behaviour:
- Storage: NBUF×NFLD words, plus per-buffer state (3-bit encoding) and len (fieldp_width bits, stored as count−1). Memory contents are not reset.
- Reset (reset=0, async): all buffers FREE; fill_ptr=0, fill_idx=0, drain_ptr=0, drain_idx=0; in_ready=0 until first clk after release; out_valid=0, out_data=0, out_last=0; buf_full=0.
- Core read: field_in = mem[bufp][fieldp] combinational, regardless of state, so the core latches it on the same edge it updates fieldp.
- Core write: at posedge with field_wen=1, mem[bufp][fieldwp] <= field_out only if state[bufp]==FULL; otherwise the write is ignored. A write cannot change len.
- buf_done: at posedge, if state[bufp]==FULL → DONE; ignored in any other state. A write and buf_done in the same cycle: the write lands, then the state changes.
- buf_full[i] = (state[i]==FULL), registered with state.
- Ingress: in_ready = (state[fill_ptr] ∈ {FREE,FILLING}). Handshake on in_valid&in_ready at posedge:
  - mem[fill_ptr][fill_idx] <= in_data.
  - state FREE → FILLING on the first byte.
  - If in_last or fill_idx==NFLD−1: len <= fill_idx; state → FULL; fill_ptr++ (wraps mod NBUF); fill_idx <= 0.
  - Otherwise fill_idx++.
  - Overflow: byte NFLD with no in_last closes the buffer; the following byte opens the next buffer.
- Egress FSM, states IDLE, LOAD, SEND:
  - IDLE: if state[drain_ptr]==DONE → state DRAINING, drain_idx=0, go to LOAD.
  - LOAD: out_data <= mem[drain_ptr][drain_idx]; out_last <= (drain_idx==len); out_valid <= 1; go to SEND.
  - SEND: hold out_* stable while !out_ready.
  - On out_valid&out_ready with out_last=0: drain_idx++, then either load the next byte in the same edge (no bubble) or go through LOAD. Minimum throughput is one byte per 2 cycles; one byte/cycle is preferred.
  - On out_last accepted: out_valid=0; state[drain_ptr] → FREE; drain_ptr++ (wrap); go to IDLE.
- Drain is strictly in ring order. A DONE buffer behind a FULL buffer at drain_ptr waits until that buffer is done.
- Ring full: fill_ptr reaches a non-FREE buffer → in_ready=0 until it is freed.
- Simultaneous events: ingress, core, and egress touch distinct buffers by state. All three may update state on the same edge for different indices; every update must take effect.
- Reset asserted mid-transfer: immediate abort; all buffers FREE, and partially filled or drained data is discarded.

Test Plan:
- Fill 3 bytes 0x11,0x22,0x33 with in_last on 0x33 → buf_full=8'b00000001; field_in with bufp=0, fieldp=1 reads 0x22; fill_ptr=1.
- Core writes 0xA5 to bufp=0, fieldwp=2, then pulses buf_done → egress emits 0x11,0x22,0xA5, out_last on 0xA5; buf 0 returns to FREE.
- 40 bytes with no in_last → buf 0 holds 32 bytes (len 31), buf 1 holds 8 bytes and stays FILLING; in_ready stays 1.
- Fill all 8 buffers, none done → in_ready=0; buf_done on buf 0 → drain; after out_last accepted, in_ready=1.
- out_ready held low 5 cycles mid-drain → out_data/out_last stable; no byte lost or duplicated.
- field_wen and buf_done to a FREE buffer → no memory or state change. reset pulled low mid-drain → out_valid=0 immediately, buf_full=0.
